ccc_lock_rst_seq: RTL and testbench

CCC_LOCK_RST_SEQ -- requirements
Module: ccc_lock_rst_seq

---
 rtl/ccc_lock_rst_seq.sv | 141 ++++++++++++++
 tb/tb_ccc_lock_rst_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ccc_lock_rst_seq.sv
// ccc_lock_rst_seq: qualifies the CCC fabric clock by waiting for a stable
// lock indication, then releases the fabric reset and later asserts READY.
// Loss of lock after reset release is counted and flagged.
module ccc_lock_rst_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic       FAB_CLK,
  input  logic       FAB_RESET,
  input  logic       FAB_LOCK,
  input  logic       SW_RST_REQ,
  input  logic       LOST_CLR,
  output logic       FABRIC_RESET,
  output logic       READY,
  output logic       LOCK_LOST,
  output logic [7:0] LOSS_CNT
);

  // The shared counter must reach the larger terminal value of the two timed states.
  localparam int CNT_MAX = ((STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES) - 1;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous lock indication into the FAB_CLK domain.
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], FAB_LOCK};
    end
  end

  // Release sequencer with registered outputs and loss bookkeeping.
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      FABRIC_RESET <= 1'b1;
      READY        <= 1'b0;
      LOCK_LOST    <= 1'b0;
      LOSS_CNT     <= 8'd0;
    end else begin
      // A loss event later in this block overrides the clear.
      if (LOST_CLR) begin
        LOCK_LOST <= 1'b0;
      end

      unique case (state)
        WAIT_LOCK: begin
          cnt          <= '0;
          FABRIC_RESET <= 1'b1;
          READY        <= 1'b0;
          if (lock_s) begin
            state <= STABLE;
          end
        end

        STABLE: begin
          // Lock dropping before release is just a restart, not a loss.
          if (!lock_s || SW_RST_REQ) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state        <= HOLD;
            cnt          <= '0;
            FABRIC_RESET <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (!lock_s) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            FABRIC_RESET <= 1'b1;
            READY        <= 1'b0;
            LOCK_LOST    <= 1'b1;
            if (LOSS_CNT != 8'hFF) begin
              LOSS_CNT <= LOSS_CNT + 8'd1;
            end
          end else if (SW_RST_REQ) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            FABRIC_RESET <= 1'b1;
            READY        <= 1'b0;
          end else if (cnt == HOLD_LAST) begin
            state <= RUN;
            cnt   <= '0;
            READY <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RUN: begin
          if (!lock_s) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            FABRIC_RESET <= 1'b1;
            READY        <= 1'b0;
            LOCK_LOST    <= 1'b1;
            if (LOSS_CNT != 8'hFF) begin
              LOSS_CNT <= LOSS_CNT + 8'd1;
            end
          end else if (SW_RST_REQ) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            FABRIC_RESET <= 1'b1;
            READY        <= 1'b0;
          end
        end

        default: begin
          state        <= WAIT_LOCK;
          cnt          <= '0;
          FABRIC_RESET <= 1'b1;
          READY        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccc_lock_rst_seq.sv
// tb_ccc_lock_rst_seq: table-driven, scoreboarded bench for ccc_lock_rst_seq
// with SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4.
module tb_ccc_lock_rst_seq;

  logic       FAB_CLK;
  logic       FAB_RESET;
  logic       FAB_LOCK;
  logic       SW_RST_REQ;
  logic       LOST_CLR;
  logic       FABRIC_RESET;
  logic       READY;
  logic       LOCK_LOST;
  logic [7:0] LOSS_CNT;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       sw;
    logic       clr;
    logic       frst;
    logic       rdy;
    logic       lost;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks;
  int   errors;

  ccc_lock_rst_seq #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .HOLD_CYCLES  (4)
  ) dut (
    .FAB_CLK     (FAB_CLK),
    .FAB_RESET   (FAB_RESET),
    .FAB_LOCK    (FAB_LOCK),
    .SW_RST_REQ  (SW_RST_REQ),
    .LOST_CLR    (LOST_CLR),
    .FABRIC_RESET(FABRIC_RESET),
    .READY       (READY),
    .LOCK_LOST   (LOCK_LOST),
    .LOSS_CNT    (LOSS_CNT)
  );

  // Free-running fabric clock.
  initial begin
    FAB_CLK = 1'b0;
    forever #5 FAB_CLK = ~FAB_CLK;
  end

  // Hard stop in case the sequence never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Append n identical one-edge records: inputs before the edge, outputs after it.
  task automatic addRun(input int n, input logic rst, input logic lock, input logic sw,
                        input logic clr, input logic frst, input logic rdy,
                        input logic lost, input logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.lock = lock; v.sw = sw; v.clr = clr;
    v.frst = frst; v.rdy = rdy; v.lost = lost; v.cnt = cnt;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic checkOutput(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (FABRIC_RESET !== e.frst || READY !== e.rdy || LOCK_LOST !== e.lost ||
        LOSS_CNT !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s: got frst=%b rdy=%b lost=%b cnt=%0d, want frst=%b rdy=%b lost=%b cnt=%0d",
               tag, FABRIC_RESET, READY, LOCK_LOST, LOSS_CNT, e.frst, e.rdy, e.lost, e.cnt);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then check after the edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    FAB_RESET  = v.rst;
    FAB_LOCK   = v.lock;
    SW_RST_REQ = v.sw;
    LOST_CLR   = v.clr;
    exp_q.push_back(v);
    @(posedge FAB_CLK);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    vec_t v;
    logic lost_prev;
    logic [7:0] cnt_prev;
    logic sw14, clr5, clr14;

    checks     = 0;
    errors     = 0;
    FAB_RESET  = 1'b1;
    FAB_LOCK   = 1'b0;
    SW_RST_REQ = 1'b0;
    LOST_CLR   = 1'b0;

    // Reset, then first release; SW_RST_REQ on the WAIT_LOCK exit edge is ignored.
    addRun(2, 1,0,0,0, 1,0,0,0);
    addRun(2, 0,1,0,0, 1,0,0,0);
    addRun(1, 0,1,1,0, 1,0,0,0);
    addRun(7, 0,1,0,0, 1,0,0,0);
    addRun(4, 0,1,0,0, 0,0,0,0);
    addRun(3, 0,1,0,0, 0,1,0,0);
    // Software rerun from RUN: one WAIT_LOCK cycle, 8 STABLE, 4 HOLD, then READY.
    addRun(1, 0,1,1,0, 1,0,0,0);
    addRun(8, 0,1,0,0, 1,0,0,0);
    addRun(4, 0,1,0,0, 0,0,0,0);
    addRun(2, 0,1,0,0, 0,1,0,0);
    // Lock low for 3 cycles in RUN: loss seen two edges after the first low sample.
    addRun(2, 0,0,0,0, 0,1,0,0);
    addRun(1, 0,0,0,0, 1,0,1,1);
    addRun(10, 0,1,0,0, 1,0,1,1);
    addRun(4, 0,1,0,0, 0,0,1,1);
    addRun(1, 0,1,0,0, 0,1,1,1);
    // LOST_CLR clears the flag but not the count.
    addRun(1, 0,1,0,1, 0,1,0,1);
    addRun(1, 0,1,0,0, 0,1,0,1);
    // One-cycle lock glitch in STABLE restarts the count without a loss.
    addRun(1, 0,1,1,0, 1,0,0,1);
    addRun(3, 0,1,0,0, 1,0,0,1);
    addRun(1, 0,0,0,0, 1,0,0,1);
    addRun(10, 0,1,0,0, 1,0,0,1);
    addRun(4, 0,1,0,0, 0,0,0,1);
    addRun(1, 0,1,0,0, 0,1,0,1);
    // FAB_RESET in HOLD wins over SW_RST_REQ and clears everything incl. the synchronizer.
    addRun(1, 0,1,1,0, 1,0,0,1);
    addRun(8, 0,1,0,0, 1,0,0,1);
    addRun(2, 0,1,0,0, 0,0,0,1);
    addRun(1, 1,1,1,0, 1,0,0,0);
    addRun(10, 0,1,0,0, 1,0,0,0);
    addRun(4, 0,1,0,0, 0,0,0,0);
    addRun(1, 0,1,0,0, 0,1,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("table[%0d]", i));
    end

    // Back to a clean reset with lock low before the loss-count stress.
    v.rst = 1; v.lock = 0; v.sw = 0; v.clr = 0;
    v.frst = 1; v.rdy = 0; v.lost = 0; v.cnt = 8'd0;
    applyStimulus(v, "stress_reset");

    // 300 loss events, each taken in HOLD; some coincide with SW_RST_REQ or LOST_CLR.
    lost_prev = 1'b0;
    cnt_prev  = 8'd0;
    for (int i = 1; i <= 300; i++) begin
      sw14  = (i % 2) == 1;
      clr5  = (i % 50) == 0;
      clr14 = (i % 7) == 0;
      for (int k = 1; k <= 14; k++) begin
        v.rst  = 1'b0;
        v.lock = (k <= 11);
        v.sw   = (k == 14) && sw14;
        v.clr  = ((k == 5) && clr5) || ((k == 14) && clr14);
        v.rdy  = 1'b0;
        v.frst = (k <= 10 || k == 14);
        if (k == 14) begin
          v.lost = 1'b1;
          v.cnt  = (i > 255) ? 8'd255 : 8'(i);
        end else begin
          v.lost = (clr5 && k >= 5) ? 1'b0 : lost_prev;
          v.cnt  = cnt_prev;
        end
        applyStimulus(v, $sformatf("loss[%0d].%0d", i, k));
      end
      lost_prev = 1'b1;
      cnt_prev  = (i > 255) ? 8'd255 : 8'(i);
    end

    // Saturated count survives LOST_CLR; FAB_RESET finally clears it.
    v.rst = 0; v.lock = 0; v.sw = 0; v.clr = 1;
    v.frst = 1; v.rdy = 0; v.lost = 0; v.cnt = 8'd255;
    applyStimulus(v, "sat_clr");
    v.clr = 0;
    applyStimulus(v, "sat_hold");
    v.rst = 1; v.cnt = 8'd0;
    applyStimulus(v, "sat_reset");

    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
